pc_counter_node: RTL and testbench

Performance-counter responder node for the pc ring: sits in series on a module's pcIn/pcOut chain and counts handshake events on up to NUM_PORTS decoupled ports of the host module. Request packets addressed to MODULE_ID are answered in place, with the selected counter value and `request` cleared. All other packets are forwarded unchanged. Every packet is delayed by exactly one register stage, so nodes can be chained without combinational paths.

---
 rtl/pc_counter_node.sv | 149 ++++++++++++++
 tb/tb_pc_counter_node.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_counter_node.sv
// pc_counter_node: performance-counter responder on the pc ring. It counts
// XFER/STALL/IDLE handshake events per monitored port plus a node cycle counter.
// Latency is one register stage. The ring has no backpressure: every valid
// input packet produces a valid output packet one cycle later.
//
// Ports:
//   clk, reset            - rising-edge clock, async active-high reset
//   port_valid/port_ready - handshake pair of monitored port i at bit i
//   io_pcIn_*             - upstream ring packet (no ready)
//   io_pcOut_*            - downstream ring packet, fully registered
module pc_counter_node #(
  parameter logic [15:0] MODULE_ID = 16'h0001,
  parameter int          NUM_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] port_valid,
  input  logic [NUM_PORTS-1:0] port_ready,
  input  logic                 io_pcIn_valid,
  input  logic                 io_pcIn_bits_request,
  input  logic [15:0]          io_pcIn_bits_moduleId,
  input  logic [7:0]           io_pcIn_bits_portId,
  input  logic [15:0]          io_pcIn_bits_pcValue,
  input  logic [3:0]           io_pcIn_bits_pcType,
  output logic                 io_pcOut_valid,
  output logic                 io_pcOut_bits_request,
  output logic [15:0]          io_pcOut_bits_moduleId,
  output logic [7:0]           io_pcOut_bits_portId,
  output logic [15:0]          io_pcOut_bits_pcValue,
  output logic [3:0]           io_pcOut_bits_pcType
);

  localparam logic [7:0] CYC_PORT   = 8'hFF;
  localparam logic [3:0] TYPE_XFER  = 4'd0;
  localparam logic [3:0] TYPE_STALL = 4'd1;
  localparam logic [3:0] TYPE_IDLE  = 4'd2;
  localparam logic [3:0] TYPE_CLEAR = 4'd3;

  logic [15:0] xfer_cnt  [NUM_PORTS];
  logic [15:0] stall_cnt [NUM_PORTS];
  logic [15:0] idle_cnt  [NUM_PORTS];
  logic [15:0] cyc_cnt;

  logic [NUM_PORTS-1:0] ev_xfer;
  logic [NUM_PORTS-1:0] ev_stall;
  logic [NUM_PORTS-1:0] ev_idle;
  logic [NUM_PORTS-1:0] clr;

  logic        port_ok;
  logic        cyc_ok;
  logic        hit;
  logic [15:0] sel_xfer;
  logic [15:0] sel_stall;
  logic [15:0] sel_idle;
  logic [15:0] sel_value;

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic ev);
    return (ev && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  assign ev_xfer  = port_valid & port_ready;
  assign ev_stall = port_valid & ~port_ready;
  assign ev_idle  = port_ready & ~port_valid;

  always_comb begin
    sel_xfer  = '0;
    sel_stall = '0;
    sel_idle  = '0;
    clr       = '0;
    port_ok   = (io_pcIn_bits_portId < 8'(NUM_PORTS)) && (io_pcIn_bits_pcType <= TYPE_CLEAR);
    cyc_ok    = (io_pcIn_bits_portId == CYC_PORT) && (io_pcIn_bits_pcType == TYPE_XFER);
    hit       = io_pcIn_valid && io_pcIn_bits_request &&
                (io_pcIn_bits_moduleId == MODULE_ID) && (port_ok || cyc_ok);

    // Port mux written as a compare loop so an 8-bit portId never indexes
    // the small counter arrays directly.
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (io_pcIn_bits_portId == 8'(i)) begin
        sel_xfer  = xfer_cnt[i];
        sel_stall = stall_cnt[i];
        sel_idle  = idle_cnt[i];
        clr[i]    = hit && (io_pcIn_bits_pcType == TYPE_CLEAR);
      end
    end

    // Reported value always comes from the registers, i.e. before this
    // cycle's update.
    if (io_pcIn_bits_portId == CYC_PORT) begin
      sel_value = cyc_cnt;
    end else begin
      case (io_pcIn_bits_pcType)
        TYPE_XFER, TYPE_CLEAR: sel_value = sel_xfer;
        TYPE_STALL:            sel_value = sel_stall;
        TYPE_IDLE:             sel_value = sel_idle;
        default:               sel_value = '0;
      endcase
    end
  end

  // Counters. A clear wins over the old value but still records an event
  // landing in the same cycle, so nothing is lost across a read-and-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        xfer_cnt[i]  <= '0;
        stall_cnt[i] <= '0;
        idle_cnt[i]  <= '0;
      end
    end else begin
      cyc_cnt <= sat_inc(cyc_cnt, 1'b1);
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (clr[i]) begin
          xfer_cnt[i]  <= {15'd0, ev_xfer[i]};
          stall_cnt[i] <= {15'd0, ev_stall[i]};
          idle_cnt[i]  <= {15'd0, ev_idle[i]};
        end else begin
          xfer_cnt[i]  <= sat_inc(xfer_cnt[i], ev_xfer[i]);
          stall_cnt[i] <= sat_inc(stall_cnt[i], ev_stall[i]);
          idle_cnt[i]  <= sat_inc(idle_cnt[i], ev_idle[i]);
        end
      end
    end
  end

  // Output stage. Bits only load on a valid packet so they hold otherwise;
  // reset drops whatever packet was in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_pcOut_valid         <= 1'b0;
      io_pcOut_bits_request  <= 1'b0;
      io_pcOut_bits_moduleId <= '0;
      io_pcOut_bits_portId   <= '0;
      io_pcOut_bits_pcValue  <= '0;
      io_pcOut_bits_pcType   <= '0;
    end else begin
      io_pcOut_valid <= io_pcIn_valid;
      if (io_pcIn_valid) begin
        io_pcOut_bits_request  <= hit ? 1'b0 : io_pcIn_bits_request;
        io_pcOut_bits_moduleId <= io_pcIn_bits_moduleId;
        io_pcOut_bits_portId   <= io_pcIn_bits_portId;
        io_pcOut_bits_pcValue  <= hit ? sel_value : io_pcIn_bits_pcValue;
        io_pcOut_bits_pcType   <= io_pcIn_bits_pcType;
      end
    end
  end

endmodule

// File: tb/tb_pc_counter_node.sv
// Testbench for pc_counter_node: directed packets with literal expectations
// plus a per-cycle comparison against an arithmetic model of the counters.
module tb_pc_counter_node;

  localparam logic [15:0] MID = 16'h0001;
  localparam int          NP  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NP-1:0] pv, pr;
  logic          in_vld, in_req;
  logic [15:0]   in_mid, in_val;
  logic [7:0]    in_pid;
  logic [3:0]    in_typ;
  logic          o_vld, o_req;
  logic [15:0]   o_mid, o_val;
  logic [7:0]    o_pid;
  logic [3:0]    o_typ;
  logic [44:0]   o_pkt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_counter_node #(.MODULE_ID(MID), .NUM_PORTS(NP)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .port_valid            (pv),
    .port_ready            (pr),
    .io_pcIn_valid         (in_vld),
    .io_pcIn_bits_request  (in_req),
    .io_pcIn_bits_moduleId (in_mid),
    .io_pcIn_bits_portId   (in_pid),
    .io_pcIn_bits_pcValue  (in_val),
    .io_pcIn_bits_pcType   (in_typ),
    .io_pcOut_valid        (o_vld),
    .io_pcOut_bits_request (o_req),
    .io_pcOut_bits_moduleId(o_mid),
    .io_pcOut_bits_portId  (o_pid),
    .io_pcOut_bits_pcValue (o_val),
    .io_pcOut_bits_pcType  (o_typ)
  );

  assign o_pkt = {o_req, o_mid, o_pid, o_val, o_typ};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_cnt [NP][3];   // [port][0=xfer,1=stall,2=idle]
  int          m_cyc;
  logic        m_vld;
  logic [44:0] m_pkt;

  always @(posedge clk or posedge reset) begin
    logic hit;
    int   v, ev;
    if (reset) begin
      m_vld = 1'b0;
      m_pkt = '0;
      m_cyc = 0;
      for (int p = 0; p < NP; p++)
        for (int k = 0; k < 3; k++) m_cnt[p][k] = 0;
    end else begin
      hit = in_vld && in_req && (in_mid == MID) &&
            ((int'(in_pid) < NP && int'(in_typ) <= 3) || (in_pid == 8'hFF && in_typ == 4'd0));
      v = 0;
      if (hit) begin
        if (in_pid == 8'hFF) v = m_cyc;
        else v = m_cnt[int'(in_pid)][(in_typ == 4'd3) ? 0 : int'(in_typ)];
      end
      m_vld = in_vld;
      if (in_vld)
        m_pkt = hit ? {1'b0, in_mid, in_pid, 16'(v), in_typ}
                    : {in_req, in_mid, in_pid, in_val, in_typ};
      for (int p = 0; p < NP; p++) begin
        for (int k = 0; k < 3; k++) begin
          ev = (k == 0) ? int'(pv[p] & pr[p]) :
               (k == 1) ? int'(pv[p] & ~pr[p]) : int'(pr[p] & ~pv[p]);
          if (hit && in_typ == 4'd3 && int'(in_pid) == p) m_cnt[p][k] = ev;
          else if (m_cnt[p][k] + ev > 65535) m_cnt[p][k] = 65535;
          else m_cnt[p][k] = m_cnt[p][k] + ev;
        end
      end
      m_cyc = (m_cyc >= 65535) ? 65535 : m_cyc + 1;
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("valid_in_reset", 64'(o_vld), 64'd0);
    end else begin
      chk("model_valid", 64'(o_vld), 64'(m_vld));
      if (m_vld) chk("model_packet", 64'(o_pkt), 64'(m_pkt));
    end
  end

  // ---------------- stimulus helpers (called just after a negedge) -------
  task automatic send(input logic rq, input logic [15:0] mid, input logic [7:0] pid,
                      input logic [15:0] val, input logic [3:0] typ);
    in_vld = 1'b1; in_req = rq; in_mid = mid; in_pid = pid; in_val = val; in_typ = typ;
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [7:0] pid, input logic [3:0] typ,
                    input logic [15:0] exp);
    send(1'b1, MID, pid, 16'hC0DE, typ);
    chk({nm, "_vld"}, 64'(o_vld), 64'd1);
    chk({nm, "_req"}, 64'(o_req), 64'd0);
    chk(nm, 64'(o_val), 64'(exp));
  endtask

  task automatic pass(input string nm, input logic rq, input logic [15:0] mid,
                      input logic [7:0] pid, input logic [15:0] val, input logic [3:0] typ);
    send(rq, mid, pid, val, typ);
    chk({nm, "_vld"}, 64'(o_vld), 64'd1);
    chk(nm, 64'(o_pkt), 64'({rq, mid, pid, val, typ}));
  endtask

  initial begin
    int seen;
    reset = 1'b1; pv = '0; pr = '0;
    in_vld = 1'b0; in_req = 1'b0; in_mid = '0; in_pid = '0; in_val = '0; in_typ = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid", 64'(o_vld), 64'd0);
    chk("reset_fields", 64'(o_pkt), 64'd0);
    reset = 1'b0;

    // Cycle counter after ten idle edges.
    repeat (10) @(negedge clk);
    rd("cyc_after_reset", 8'hFF, 4'd0, 16'h000A);

    // Port 0: 5 transfers; port 1: 3 stalls.
    pv = 2'b11; pr = 2'b01;
    repeat (3) @(negedge clk);
    pv = 2'b01;
    repeat (2) @(negedge clk);
    pv = 2'b00; pr = 2'b00;
    rd("p0_xfer", 8'd0, 4'd0, 16'd5);
    rd("p1_stall", 8'd1, 4'd1, 16'd3);
    rd("p1_xfer", 8'd1, 4'd0, 16'd0);

    // Read-and-clear with a transfer in the same cycle.
    pv = 2'b01; pr = 2'b01;
    rd("p0_clear_read", 8'd0, 4'd3, 16'd5);
    pv = 2'b00; pr = 2'b00;
    rd("p0_xfer_after_clear", 8'd0, 4'd0, 16'd1);
    rd("p0_stall_after_clear", 8'd0, 4'd1, 16'd0);

    // Idle counting on port 1.
    pr = 2'b10;
    repeat (2) @(negedge clk);
    pr = 2'b00;
    rd("p1_idle", 8'd1, 4'd2, 16'd2);

    // Pass-through cases.
    pass("pt_foreign_id", 1'b1, MID + 16'd1, 8'd0, 16'h1234, 4'd0);
    pass("pt_response", 1'b0, MID, 8'd0, 16'h5555, 4'd0);
    pass("pt_port_range", 1'b1, MID, 8'(NP), 16'h00AA, 4'd0);
    pass("pt_bad_type", 1'b1, MID, 8'd0, 16'hBEEF, 4'd7);
    pass("pt_cyc_type1", 1'b1, MID, 8'hFF, 16'h0F0F, 4'd1);

    // Back-to-back packets, checked by the model each cycle.
    in_vld = 1'b1; in_req = 1'b1; in_mid = MID; in_pid = 8'd1; in_typ = 4'd2; in_val = 16'h0;
    @(negedge clk);
    in_req = 1'b0; in_val = 16'h7777;
    @(negedge clk);
    in_vld = 1'b0;
    @(negedge clk);

    // Saturation of port 0 STALL across FFFE -> FFFF -> FFFF.
    pv = 2'b01; pr = 2'b00;
    repeat (65534) @(negedge clk);
    rd("sat_fffe", 8'd0, 4'd1, 16'hFFFE);
    rd("sat_ffff", 8'd0, 4'd1, 16'hFFFF);
    repeat (4400) @(negedge clk);
    rd("sat_hold", 8'd0, 4'd1, 16'hFFFF);
    pv = 2'b00;
    rd("cyc_saturated", 8'hFF, 4'd0, 16'hFFFF);

    // Asynchronous reset while a hit response is registered.
    in_vld = 1'b1; in_req = 1'b1; in_mid = MID; in_pid = 8'd0; in_typ = 4'd1; in_val = '0;
    @(posedge clk);
    #1;
    chk("pre_reset_vld", 64'(o_vld), 64'd1);
    chk("pre_reset_val", 64'(o_val), 64'hFFFF);
    #1;
    reset = 1'b1;
    in_vld = 1'b0;
    #1;
    chk("async_reset_vld", 64'(o_vld), 64'd0);
    chk("async_reset_fields", 64'(o_pkt), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      seen += int'(o_vld);
    end
    chk("no_resp_after_reset", 64'(seen), 64'd0);
    rd("rst_p0_xfer", 8'd0, 4'd0, 16'd0);
    rd("rst_p0_stall", 8'd0, 4'd1, 16'd0);
    rd("rst_p0_idle", 8'd0, 4'd2, 16'd0);
    rd("rst_p1_xfer", 8'd1, 4'd0, 16'd0);
    rd("rst_p1_stall", 8'd1, 4'd1, 16'd0);
    rd("rst_p1_idle", 8'd1, 4'd2, 16'd0);
    rd("rst_cyc", 8'hFF, 4'd0, 16'd10);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
